// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module  : fir_sample_feeder
// Brief   : FIFO-buffered signed sample source that plays samples out to the
//           FIR datapath at a programmable period, with priming, underflow
//           and flush handling. Macro FEEDER_HOLD_LAST_EN: when defined, an
//           underflow strobe repeats the last sample instead of driving 0.
// Revision: 1.0  initial release
// ============================================================================
module fir_sample_feeder #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int DIV_W     = 8,
   parameter int PRIME_LVL = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic signed [DATA_W-1:0]   s_data,
   input  logic                       enable,
   input  logic [DIV_W-1:0]           rate_div,
   input  logic                       flush,
   output logic signed [DATA_W-1:0]   x_out,
   output logic                       x_strobe,
   output logic                       underflow,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;

   localparam logic [AW-1:0]    PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [LVL_W-1:0] LVL_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic signed [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]            r_wr_ptr;
   logic [AW-1:0]            r_rd_ptr;
   logic [LVL_W-1:0]         r_level;
   logic [1:0]               r_state;
   logic [DIV_W-1:0]         r_div;
   logic signed [DATA_W-1:0] r_x_out;
   logic                     r_strobe;
   logic                     r_underflow;

   logic w_full;
   logic w_empty;
   logic w_ready;
   logic w_push;
   logic w_strobe;
   logic w_pop;
   logic w_prime_ok;

   assign w_full     = (r_level == LVL_W'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_ready    = !w_full && !flush;
   assign w_push     = s_valid && w_ready;
   // >= rather than == so lowering rate_div mid-run never waits for a wrap
   assign w_strobe   = (r_state == ST_RUN) && enable && (r_div >= rate_div);
   assign w_pop      = w_strobe && !w_empty;
   assign w_prime_ok = (r_level >= LVL_W'(PRIME_LVL));

   assign s_ready   = w_ready;
   assign x_out     = r_x_out;
   assign x_strobe  = r_strobe;
   assign underflow = r_underflow;
   assign level     = r_level;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_x_out     <= '0;
         r_strobe    <= 1'b0;
         r_underflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_strobe    <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase

         r_strobe <= w_strobe;
         // No fall-through: a push into an empty FIFO waits for the next strobe
         if (w_strobe) begin
            if (!w_empty) begin
               r_x_out <= r_mem[r_rd_ptr];
            end else begin
               r_underflow <= 1'b1;
`ifdef FEEDER_HOLD_LAST_EN
               r_x_out <= r_x_out;
`else
               r_x_out <= '0;
`endif
            end
         end

         if ((r_state == ST_RUN) && enable && !w_strobe) begin
            r_div <= r_div + DIV_ONE;
         end else begin
            r_div <= '0;
         end

         case (r_state)
            ST_IDLE: begin
               if (enable) r_state <= ST_PRIME;
            end
            ST_PRIME: begin
               if (!enable)         r_state <= ST_IDLE;
               else if (w_prime_ok) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (!enable) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fir_sample_feeder
// Brief   : Self-checking bench for fir_sample_feeder against a queue-based
//           reference model stepped once per clock edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_fir_sample_feeder;

   localparam int DATA_W    = 8;
   localparam int DEPTH     = 8;
   localparam int DIV_W     = 8;
   localparam int PRIME_LVL = 2;
   localparam int LVL_W     = $clog2(DEPTH) + 1;
   localparam int VW        = LVL_W + DATA_W + 3;

   logic                     clk      = 1'b0;
   logic                     clk_run  = 1'b1;
   logic                     reset    = 1'b1;
   logic                     s_valid  = 1'b0;
   logic                     s_ready;
   logic signed [DATA_W-1:0] s_data   = '0;
   logic                     enable   = 1'b0;
   logic [DIV_W-1:0]         rate_div = '0;
   logic                     flush    = 1'b0;
   logic signed [DATA_W-1:0] x_out;
   logic                     x_strobe;
   logic                     underflow;
   logic [LVL_W-1:0]         level;

   int n_vec = 0;
   int n_err = 0;

   fir_sample_feeder #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .DIV_W    (DIV_W),
      .PRIME_LVL(PRIME_LVL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .enable   (enable),
      .rate_div (rate_div),
      .flush    (flush),
      .x_out    (x_out),
      .x_strobe (x_strobe),
      .underflow(underflow),
      .level    (level)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   // Reference model: playout mode, FIFO contents as a queue, cycles since strobe
   typedef enum {M_IDLE, M_PRIME, M_RUN} mode_t;
   mode_t                    m_mode = M_IDLE;
   logic signed [DATA_W-1:0] m_q[$];
   int                       m_cnt  = 0;
   logic signed [DATA_W-1:0] m_x    = '0;
   logic                     m_stb  = 1'b0;
   logic                     m_uf   = 1'b0;

   logic [VW-1:0] dut_vec;
   assign dut_vec = {s_ready, level, x_out, x_strobe, underflow};

   function automatic logic [VW-1:0] exp_vec();
      logic rdy;
      rdy = (m_q.size() < DEPTH) && !flush;
      return {rdy, LVL_W'(m_q.size()), m_x, m_stb, m_uf};
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_x    = '0;
      m_stb  = 1'b0;
      m_uf   = 1'b0;
   endtask

   // One clock edge: model applies the behavioural rules to the inputs seen at the edge
   task automatic tick();
      int sz;
      bit ready;
      bit push;
      bit stb;
      @(posedge clk);
      sz    = m_q.size();
      ready = (sz < DEPTH) && !flush;
      push  = s_valid && ready;
      stb   = 1'b0;
      if (flush) begin
         m_q.delete();
         m_uf   = 1'b0;
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_stb  = 1'b0;
      end else begin
         stb = (m_mode == M_RUN) && enable && (m_cnt >= int'(rate_div));
         if (stb) begin
            if (sz > 0) begin
               m_x = m_q.pop_front();
            end else begin
               m_uf = 1'b1;
`ifndef FEEDER_HOLD_LAST_EN
               m_x = '0;
`endif
            end
         end
         if (push) m_q.push_back(s_data);
         m_cnt = ((m_mode == M_RUN) && enable && !stb) ? m_cnt + 1 : 0;
         case (m_mode)
            M_IDLE:  if (enable) m_mode = M_PRIME;
            M_PRIME: begin
               if (!enable)               m_mode = M_IDLE;
               else if (sz >= PRIME_LVL)  m_mode = M_RUN;
            end
            default: if (!enable) m_mode = M_IDLE;
         endcase
         m_stb = stb;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_init: got %h expected %h", dut_vec, exp_vec());
      end
      @(negedge clk);
      reset    = 1'b1;
      enable   = 1'b1;
      rate_div = '0;
      for (int i = 0; i < 7; i++) begin
         s_valid = (i < 4);
         s_data  = DATA_W'($urandom);
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_run c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
      end
      clk_run = 1'b0;
      #7 reset = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({x_out, x_strobe, underflow, level} !== '0) begin
         n_err++;
         $display("FAIL reset_async: got x/stb/uf/lvl=%0d/%b/%b/%0d required 0/0/0/0",
                  x_out, x_strobe, underflow, level);
      end
      s_valid = 1'b0;
      enable  = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (s_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got s_ready=%b required 1", s_ready);
      end
      clk_run = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic signed [DATA_W-1:0] vals [5];
      logic signed [DATA_W-1:0] seen[$];
      logic signed [DATA_W-1:0] uf_exp;
      vals = '{8'sd5, 8'sd10, 8'sd15, 8'sd10, 8'sd5};
`ifdef FEEDER_HOLD_LAST_EN
      uf_exp = 8'sd5;
`else
      uf_exp = 8'sd0;
`endif
      enable   = 1'b1;
      rate_div = '0;
      for (int i = 0; i < 12; i++) begin
         s_valid = (i < 5);
         s_data  = (i < 5) ? vals[i] : '0;
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL basic c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
         if (x_strobe) seen.push_back(x_out);
      end
      n_vec++;
      if (seen.size() < 6) begin
         n_err++;
         $display("FAIL basic_count: got %0d strobes required at least 6", seen.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (seen[k] !== vals[k]) begin
               n_err++;
               $display("FAIL basic_order[%0d]: got %0d required %0d", k, seen[k], vals[k]);
            end
         end
         n_vec++;
         if (seen[5] !== uf_exp || underflow !== 1'b1) begin
            n_err++;
            $display("FAIL basic_underflow: got x=%0d uf=%b required x=%0d uf=1",
                     seen[5], underflow, uf_exp);
         end
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_rate();
      int stb_cyc[$];
      logic signed [DATA_W-1:0] stb_val[$];
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      enable   = 1'b0;
      rate_div = DIV_W'(3);
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'(i + 1);
         tick();
      end
      s_valid = 1'b0;
      enable  = 1'b1;
      for (int c = 0; c < 16; c++) begin
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL rate c%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
         tick();
         if (x_strobe) begin
            stb_cyc.push_back(c);
            stb_val.push_back(x_out);
         end
      end
      n_vec++;
      if (stb_cyc.size() != 3) begin
         n_err++;
         $display("FAIL rate_count: got %0d strobes required 3", stb_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (stb_val[k] !== DATA_W'(k + 1) ||
                (k > 0 && stb_cyc[k] - stb_cyc[k-1] != 4)) begin
               n_err++;
               $display("FAIL rate_strobe[%0d]: got x=%0d cyc=%0d required x=%0d period 4",
                        k, stb_val[k], stb_cyc[k], k + 1);
            end
         end
      end
      rate_div = '0;
      tick();
      n_vec++;
      if (x_strobe !== 1'b1 || x_out !== 8'sd4) begin
         n_err++;
         $display("FAIL rate_change: got stb=%b x=%0d required stb=1 x=4", x_strobe, x_out);
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_full();
      bit got;
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      enable   = 1'b0;
      rate_div = '0;
      s_valid  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s_data = DATA_W'($urandom);
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL full_fill c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         if (i < 8) tick();
      end
      n_vec++;
      if (level !== LVL_W'(8) || s_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_level: got lvl=%0d rdy=%b required lvl=8 rdy=0", level, s_ready);
      end
      tick();
      enable = 1'b1;
      got    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL full_drain c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
         n_vec++;
         if (x_strobe && !got) begin
            got = 1'b1;
            if (s_ready !== 1'b1 || level !== LVL_W'(7)) begin
               n_err++;
               $display("FAIL full_reopen: got rdy=%b lvl=%0d required rdy=1 lvl=7", s_ready, level);
            end
         end else if (!got && s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_closed c%0d: got rdy=%b required 0", i, s_ready);
         end
      end
      s_valid = 1'b0;
      enable  = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      logic signed [DATA_W-1:0] x_hold;
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      enable   = 1'b1;
      rate_div = '0;
      for (int i = 0; i < 8; i++) begin
         s_valid = (i < 2);
         s_data  = DATA_W'($urandom);
         tick();
      end
      rate_div = DIV_W'(200);
      s_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = DATA_W'($urandom);
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL flush_fill c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
      end
      n_vec++;
      if (level !== LVL_W'(5) || underflow !== 1'b1) begin
         n_err++;
         $display("FAIL flush_pre: got lvl=%0d uf=%b required lvl=5 uf=1", level, underflow);
      end
      x_hold = x_out;
      flush  = 1'b1;
      s_data = DATA_W'($urandom);
      #1;
      n_vec++;
      if (s_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_ready: got rdy=%b required 0", s_ready);
      end
      tick();
      n_vec++;
      if (level !== '0 || underflow !== 1'b0 || x_strobe !== 1'b0 || x_out !== x_hold) begin
         n_err++;
         $display("FAIL flush_clear: got lvl=%0d uf=%b stb=%b x=%0d required 0/0/0/%0d",
                  level, underflow, x_strobe, x_out, x_hold);
      end
      flush   = 1'b0;
      s_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL flush_after c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
      end
      enable = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      enable   = 1'b0;
      rate_div = '0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'($urandom);
         tick();
      end
      s_valid = 1'b0;
      enable  = 1'b1;
      tick();
      tick();
      s_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_data = DATA_W'($urandom);
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL b2b c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
         n_vec++;
         if (level !== LVL_W'(3) || x_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_level c%0d: got lvl=%0d stb=%b required lvl=3 stb=1", i, level, x_strobe);
         end
      end
      s_valid = 1'b0;
      enable  = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (i % 16 == 0) rate_div = DIV_W'($urandom_range(0, 3));
         s_valid = 1'($urandom_range(0, 1));
         s_data  = DATA_W'($urandom);
         enable  = ($urandom_range(0, 19) != 0);
         flush   = ($urandom_range(0, 39) == 0);
         #1;
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++;
            $display("FAIL random c%0d: got %h expected %h", i, dut_vec, exp_vec());
         end
         tick();
      end
      flush   = 1'b0;
      s_valid = 1'b0;
      enable  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rate();
      test_full();
      test_flush();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
